fetch_ctrl_rv32i: RTL and testbench

- Instruction-fetch sequencer for the RV32I core.
- Owns the program counter, issues single-outstanding requests to instruction memory over a valid/ready request/response interface, and buffers one fetched instruction for decode.
- Applies branch/jump redirects with priority, discarding any stale in-flight response.

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/fetch_buf_rv32i.sv | 45 ++++
 rtl/fetch_ctrl_rv32i.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_ctrl_rv32i.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the RV32I instruction-fetch slice:
//   RV_RESET_VECTOR : default PC loaded on reset
//   RV_PC_STEP      : default sequential fetch increment (bytes)
//   fetch_state_e   : fetch controller states (HALT only reachable when
//                     built with MISALIGN_TRAP_EN)
//   fetch_entry_t   : one buffered instruction and its PC
//   pc_align / pc_misaligned : word-alignment helpers for redirect targets
package rv32i_pkg;

  localparam logic [31:0] RV_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] RV_PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    FULL,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_buf_rv32i.sv
// fetch_buf_rv32i
// One-entry holding register for a fetched instruction and its PC.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : capture i_pc/i_instr and mark the entry valid
//   i_clear   : drop the entry (consume or flush); wins over i_load
//   i_pc      : PC of the instruction being captured
//   i_instr   : instruction word being captured
//   o_valid   : entry holds an instruction
//   o_pc      : PC of the held instruction
//   o_instr   : held instruction word
module fetch_buf_rv32i
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic         r_valid;
  fetch_entry_t r_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= '{pc: i_pc, instr: i_instr};
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_entry.pc;
  assign o_instr = r_entry.instr;

endmodule

// File: rtl/fetch_ctrl_rv32i.sv
// fetch_ctrl_rv32i
// Instruction-fetch sequencer for the RV32I core. Owns the PC, issues one
// outstanding request at a time to instruction memory, buffers one fetched
// instruction for decode, and applies redirects with highest priority,
// discarding any stale in-flight response.
// Parameters:
//   RESET_VECTOR : PC loaded on reset
//   PC_STEP      : sequential increment in bytes
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   redirect_valid / redirect_pc  : one-cycle PC redirect (branch/jump/trap)
//   imem_req_valid/ready/addr     : fetch request handshake, addr = PC
//   imem_rsp_valid / imem_rsp_data: fetch response
//   if_valid / if_ready           : buffered instruction handshake to decode
//   if_pc / if_instr              : buffered instruction and its PC
//   fetch_misaligned              : sticky misaligned-redirect flag
// Build option:
//   MISALIGN_TRAP_EN : a redirect with target[1:0]!=0 sets fetch_misaligned
//                      and halts fetching until reset. Without it the low
//                      target bits are forced to zero.
module fetch_ctrl_rv32i
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RV_RESET_VECTOR,
  parameter logic [31:0] PC_STEP      = RV_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  // r_run holds off the first request until one clock edge after reset
  // releases, so no request is presented during the reset cycle.
  logic         r_run;
  fetch_state_e r_state,    w_state_nxt;
  logic [31:0]  r_pc,       w_pc_nxt;
  logic         r_drop,     w_drop_nxt;
  logic         r_pend_vld, w_pend_vld_nxt;
  logic [31:0]  r_pend_pc,  w_pend_pc_nxt;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic         w_req_valid;
  logic [31:0]  w_redir_pc;

`ifdef MISALIGN_TRAP_EN
  logic r_misaligned;
  logic w_mis_set;
  logic w_redir_bad;

  assign w_redir_pc       = redirect_pc;
  assign w_redir_bad      = redirect_valid && pc_misaligned(redirect_pc) &&
                            (r_state != HALT);
  assign fetch_misaligned = r_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else if (w_mis_set) begin
      r_misaligned <= 1'b1;
    end
  end
`else
  logic w_unused_lsb;

  assign w_unused_lsb = ^redirect_pc[1:0];
  assign w_redir_pc   = pc_align(redirect_pc);
`endif

  assign w_req_valid    = r_run && (r_state == REQ);
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run      <= 1'b0;
      r_state    <= REQ;
      r_pc       <= RESET_VECTOR;
      r_drop     <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
    end else begin
      r_run      <= 1'b1;
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drop_nxt     = r_drop;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_pc_nxt  = r_pend_pc;
    w_buf_load     = 1'b0;
    w_buf_clear    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    w_mis_set      = 1'b0;

    if (w_redir_bad) begin
      w_mis_set      = 1'b1;
      w_state_nxt    = HALT;
      w_pc_nxt       = redirect_pc;
      w_buf_clear    = 1'b1;
      w_pend_vld_nxt = 1'b0;
      w_drop_nxt     = 1'b0;
    end else begin
`else
    begin
`endif
      if (redirect_valid) begin
        w_buf_clear = 1'b1;
      end

      case (r_state)
        REQ: begin
          if (!w_req_valid) begin
            // Nothing presented yet, so the target can be taken directly.
            if (redirect_valid) begin
              w_pc_nxt = w_redir_pc;
            end
          end else if (imem_req_ready) begin
            // The request at the old PC goes out regardless; a redirect now
            // or an earlier pending one marks its response as stale.
            w_state_nxt    = WAIT;
            w_pend_vld_nxt = 1'b0;
            if (redirect_valid) begin
              w_pc_nxt   = w_redir_pc;
              w_drop_nxt = 1'b1;
            end else if (r_pend_vld) begin
              w_pc_nxt   = r_pend_pc;
              w_drop_nxt = 1'b1;
            end
          end else if (redirect_valid) begin
            // Address must stay stable until accepted: park the target.
            w_pend_vld_nxt = 1'b1;
            w_pend_pc_nxt  = w_redir_pc;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            w_pc_nxt = w_redir_pc;
            if (imem_rsp_valid) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = REQ;
            end else begin
              w_drop_nxt  = 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (r_drop) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = REQ;
            end else begin
              w_buf_load  = 1'b1;
              w_pc_nxt    = r_pc + PC_STEP;
              w_state_nxt = FULL;
            end
          end
        end

        FULL: begin
          if (redirect_valid) begin
            w_pc_nxt    = w_redir_pc;
            w_state_nxt = REQ;
          end else if (if_ready) begin
            w_buf_clear = 1'b1;
            w_state_nxt = REQ;
          end
        end

`ifdef MISALIGN_TRAP_EN
        HALT: begin
          w_state_nxt = HALT;
        end
`endif

        default: begin
          w_state_nxt = REQ;
        end
      endcase
    end
  end

  fetch_buf_rv32i u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_pc),
    .i_instr (imem_rsp_data),
    .o_valid (if_valid),
    .o_pc    (if_pc),
    .o_instr (if_instr)
  );

endmodule

// File: tb/tb_fetch_ctrl_rv32i.sv
// tb_fetch_ctrl_rv32i
// Self-checking bench for fetch_ctrl_rv32i. A memory responder answers each
// accepted request after a random delay with a word derived from its
// address; a stream-level model tracks which PC decode must receive next
// (sequential, or the latest redirect target) and checks every consumed
// instruction against it, plus handshake stability and flush behaviour.
// Directed scenarios run first, followed by a randomized phase with a
// mid-run asynchronous reset. MISALIGN_TRAP_EN selects the trap scenario.
module tb_fetch_ctrl_rv32i;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  fetch_ctrl_rv32i #(
    .RESET_VECTOR (RV),
    .PC_STEP      (32'd4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  initial forever #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Stimulus knobs (percentages / delay range)
  int unsigned k_ready, k_dmin, k_dmax, k_ifr, k_redir, k_spur;
  bit          k_const;
  logic        f_redir = 1'b0;
  logic [31:0] f_redir_pc = '0;

  // Reference model state
  logic [31:0] exp_pc;
  logic        outst;
  logic [31:0] outst_addr;
  int unsigned outst_wait;
  int unsigned cyc;
  int unsigned total_deliv;
  logic [31:0] acc_q[$];
  logic [31:0] deliv_pc_q[$];
  int unsigned deliv_cyc_q[$];

  // Values seen/driven for the upcoming clock edge
  logic        p_req_valid, p_if_valid, p_ready, p_rsp, p_ifr, p_redir;
  logic [31:0] p_req_addr, p_if_pc, p_redir_pc;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (k_const) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 + ($urandom_range(3) << 2);
    else                        t = RV + ($urandom_range(1023) << 2);
`ifndef MISALIGN_TRAP_EN
    t[1:0] = 2'($urandom_range(3));
`endif
    return t;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int unsigned i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic sample_outputs();
    p_req_valid = imem_req_valid;
    p_req_addr  = imem_req_addr;
    p_if_valid  = if_valid;
    p_if_pc     = if_pc;
  endtask

  // Advance one clock edge, account for what that edge did, check outputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (p_if_valid && p_ifr && !p_redir) begin
      check_eq("if_pc", p_if_pc, exp_pc);
      check_eq("if_instr", if_instr, memf(p_if_pc));
      deliv_pc_q.push_back(p_if_pc);
      deliv_cyc_q.push_back(cyc);
      total_deliv++;
      exp_pc += 32'd4;
    end
    if (p_redir) exp_pc = {p_redir_pc[31:2], 2'b00};
    if (p_rsp && outst) outst = 1'b0;
    if (p_req_valid && p_ready) begin
      outst      = 1'b1;
      outst_addr = p_req_addr;
      outst_wait = $urandom_range(k_dmax, k_dmin);
      acc_q.push_back(p_req_addr);
    end
    if (p_redir) check_eq("flush", 32'(if_valid), 32'd0);
    if (p_req_valid && !p_ready) begin
      check_eq("req_hold_valid", 32'(imem_req_valid), 32'd1);
      check_eq("req_hold_addr", imem_req_addr, p_req_addr);
    end
    if (p_if_valid && !p_ifr && !p_redir) begin
      check_eq("buf_hold_valid", 32'(if_valid), 32'd1);
      check_eq("buf_hold_pc", if_pc, p_if_pc);
    end
    sample_outputs();
  endtask

  // Choose inputs for the next clock edge.
  task automatic drive();
    imem_req_ready = ($urandom_range(99) < k_ready);
    if (outst) begin
      if (outst_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(outst_addr);
      end else begin
        outst_wait--;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end else begin
      imem_rsp_valid = ($urandom_range(99) < k_spur);
      imem_rsp_data  = $urandom;
    end
    if_ready = ($urandom_range(99) < k_ifr);
    if (f_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_redir_pc;
      f_redir        = 1'b0;
    end else if ($urandom_range(99) < k_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_target();
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    p_ready    = imem_req_ready;
    p_rsp      = imem_rsp_valid;
    p_ifr      = if_ready;
    p_redir    = redirect_valid;
    p_redir_pc = redirect_pc;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      drive();
    end
  endtask

  task automatic set_knobs(input int unsigned rdy, input int unsigned dmin,
                           input int unsigned dmax, input int unsigned ifr,
                           input int unsigned redir, input int unsigned spur,
                           input bit cst);
    k_ready = rdy; k_dmin = dmin; k_dmax = dmax; k_ifr = ifr;
    k_redir = redir; k_spur = spur; k_const = cst;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b0;
    exp_pc = RV;
    outst  = 1'b0;
    cyc    = 0;
    acc_q.delete();
    deliv_pc_q.delete();
    deliv_cyc_q.delete();
    sample_outputs();
    p_ready = 1'b0; p_rsp = 1'b0; p_ifr = 1'b0; p_redir = 1'b0; p_redir_pc = '0;
    check_eq("release_no_req", 32'(imem_req_valid), 32'd0);
  endtask

  initial begin
    logic        seen;
    int unsigned reqs;

    total_deliv = 0;
    set_knobs(100, 0, 0, 100, 0, 0, 1'b1);

    // Zero-wait memory returning a NOP: three sequential fetches, 3-cycle cadence
    do_reset();
    step();
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("first_req_addr", imem_req_addr, RV);
    drive();
    run(11);
    check_eq("seq_acc0", q_at(acc_q, 0), RV);
    check_eq("seq_acc1", q_at(acc_q, 1), RV + 32'd4);
    check_eq("seq_acc2", q_at(acc_q, 2), RV + 32'd8);
    check_eq("seq_pc2", q_at(deliv_pc_q, 2), RV + 32'd8);
    if (deliv_cyc_q.size() >= 3) begin
      check_eq("thru_gap1", deliv_cyc_q[1] - deliv_cyc_q[0], 32'd3);
      check_eq("thru_gap2", deliv_cyc_q[2] - deliv_cyc_q[1], 32'd3);
    end else begin
      check_eq("thru_count", deliv_cyc_q.size(), 32'd3);
    end

    // Request stalled for 5 cycles
    set_knobs(0, 0, 0, 100, 0, 0, 1'b0);
    do_reset();
    step(); drive();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_valid", 32'(imem_req_valid), 32'd1);
      check_eq("stall_addr", imem_req_addr, RV);
      drive();
    end
    k_ready = 100;
    run(8);
    check_eq("stall_acc0", q_at(acc_q, 0), RV);

    // Redirect during WAIT, response arrives later and must be dropped
    set_knobs(100, 2, 2, 100, 0, 0, 1'b0);
    do_reset();
    step(); drive();
    step();
    check_eq("wait_entered", 32'(imem_req_valid), 32'd0);
    f_redir = 1'b1; f_redir_pc = 32'h0040_0100;
    drive();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | if_valid;
      if (acc_q.size() >= 2) break;
      drive();
    end
    check_eq("wait_redir_no_valid", 32'(seen), 32'd0);
    check_eq("wait_redir_next_addr", q_at(acc_q, 1), 32'h0040_0100);
    drive();
    run(10);
    check_eq("wait_redir_deliv", q_at(deliv_pc_q, 0), 32'h0040_0100);

    // Redirect in FULL together with if_ready
    set_knobs(100, 0, 0, 0, 0, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      if (if_valid) break;
      drive();
    end
    check_eq("full_reached", 32'(if_valid), 32'd1);
    k_ifr = 100;
    f_redir = 1'b1; f_redir_pc = 32'h0040_0200;
    drive();
    step();
    check_eq("full_redir_flush", 32'(if_valid), 32'd0);
    check_eq("full_redir_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("full_redir_req_addr", imem_req_addr, 32'h0040_0200);
    drive();
    run(10);
    check_eq("full_redir_deliv", q_at(deliv_pc_q, 0), 32'h0040_0200);

    // Redirect while request stalled, then accepted
    set_knobs(0, 1, 1, 100, 0, 0, 1'b0);
    do_reset();
    step();
    f_redir = 1'b1; f_redir_pc = 32'h0040_0300;
    drive();
    run(3);
    check_eq("pend_addr_held", imem_req_addr, RV);
    k_ready = 100;
    run(12);
    check_eq("pend_acc0", q_at(acc_q, 0), RV);
    check_eq("pend_acc1", q_at(acc_q, 1), 32'h0040_0300);
    check_eq("pend_deliv", q_at(deliv_pc_q, 0), 32'h0040_0300);

    // PC wraps past the top of the address space
    set_knobs(100, 0, 0, 100, 0, 0, 1'b0);
    do_reset();
    step();
    f_redir = 1'b1; f_redir_pc = 32'hFFFF_FFF8;
    drive();
    run(16);
    check_eq("wrap_pc0", q_at(deliv_pc_q, 0), 32'hFFFF_FFF8);
    check_eq("wrap_pc1", q_at(deliv_pc_q, 1), 32'hFFFF_FFFC);
    check_eq("wrap_pc2", q_at(deliv_pc_q, 2), 32'h0000_0000);

    // Misaligned redirect target
    set_knobs(100, 0, 0, 100, 0, 0, 1'b0);
    do_reset();
    step();
    f_redir = 1'b1; f_redir_pc = 32'h0040_0102;
    drive();
`ifdef MISALIGN_TRAP_EN
    step();
    check_eq("mis_flag", 32'(fetch_misaligned), 32'd1);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      drive();
      step();
      reqs += 32'(imem_req_valid);
    end
    check_eq("mis_no_req", reqs, 32'd0);
    check_eq("mis_no_valid", 32'(if_valid), 32'd0);
    check_eq("mis_sticky", 32'(fetch_misaligned), 32'd1);
`else
    reqs = 0;
    run(10);
    check_eq("align_deliv", q_at(deliv_pc_q, 0), 32'h0040_0100);
`endif

    // Randomized traffic with a mid-run asynchronous reset
    total_deliv = 0;
    set_knobs(70, 0, 3, 60, 6, 10, 1'b0);
    do_reset();
    run(1500);
    step();
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_req", 32'(imem_req_valid), 32'd0);
    check_eq("async_rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("async_rst_if_pc", if_pc, 32'd0);
    do_reset();
    run(1500);
    check_eq("rand_deliveries_min", 32'(total_deliv >= 32'd100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
